// File: rtl/serial_block_assembler_pkg.sv
// Shared definitions for the serial/parallel block conversion path.
// Holds the FSM state type and block-geometry helper functions.
package serial_block_assembler_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } sba_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned bytes_per_block(input int unsigned width);
    return (4 * width) / 8;
  endfunction

endpackage

// File: rtl/serial_block_assembler_if.sv
// Byte-serial input and block-parallel output handshake bundle for one lane.
interface serial_block_assembler_if #(
  parameter int unsigned MAX_WORD_LENGTH = 32
);
  logic                           byte_valid;
  logic [7:0]                     byte_in;
  logic                           frame_start;
  logic                           byte_ready;
  logic                           par_valid;
  logic [4*MAX_WORD_LENGTH-1:0]   par_data;
  logic                           par_ready;
  logic                           frame_error;
  logic [15:0]                    blocks_done;

  modport master (
    output byte_valid, byte_in, frame_start, par_ready,
    input  byte_ready, par_valid, par_data, frame_error, blocks_done
  );

  modport slave (
    input  byte_valid, byte_in, frame_start, par_ready,
    output byte_ready, par_valid, par_data, frame_error, blocks_done
  );
endinterface

// File: rtl/serial_block_assembler_block_buffer.sv
// Two-deep FIFO for completed blocks; slot0 is always the head and
// empty slots are kept at zero so the head reads zero when empty.
module block_buffer_2entry #(
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic [1:0]       occupancy_o
);
  logic [WIDTH-1:0] slot0_q, slot1_q;
  logic [1:0]       occ_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (occ_q != 2'd0);
  assign do_push = push_i && ((occ_q != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      occ_q   <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (occ_q == 2'd0) slot0_q <= push_data_i;
          else               slot1_q <= push_data_i;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          slot0_q <= slot1_q;
          slot1_q <= '0;
          occ_q   <= occ_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: the new block lands behind whatever remains.
          if (occ_q == 2'd1) begin
            slot0_q <= push_data_i;
          end else begin
            slot0_q <= slot1_q;
            slot1_q <= push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid_o     = (occ_q != 2'd0);
  assign head_o      = valid_o ? slot0_q : '0;
  assign occupancy_o = occ_q;
endmodule

// File: rtl/serial_block_assembler.sv
// Reassembles little-endian byte-serial frames into 4-word blocks and
// hands them to downstream consumers through a 2-entry buffer.
module serial_block_assembler
  import serial_block_assembler_pkg::*;
#(
  parameter int unsigned MAX_WORD_LENGTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  serial_block_assembler_if.slave  bus
);
  localparam int unsigned BLOCK_W = 4 * MAX_WORD_LENGTH;
  localparam int unsigned BPB     = bytes_per_block(MAX_WORD_LENGTH);
  localparam int unsigned CNT_W   = (clog2(BPB) > 0) ? clog2(BPB) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BPB - 1);

  sba_state_e         state_q;
  logic [CNT_W-1:0]   count_q;
  logic [BLOCK_W-1:0] asm_q, asm_d;
  logic               frame_error_q;
  logic [15:0]        blocks_done_q;

  logic               accept, store, last;
  logic [CNT_W-1:0]   pos;
  logic [1:0]         occupancy;
  logic               buf_valid;
  logic [BLOCK_W-1:0] buf_head;

  assign bus.byte_ready = reset && (occupancy != 2'd2);
  assign accept         = bus.byte_valid && bus.byte_ready;

  // A frame_start byte always restarts at position 0, from either state.
  always_comb begin
    pos   = bus.frame_start ? '0 : count_q;
    store = accept && (bus.frame_start || (state_q == COLLECT));
    last  = store && (pos == LAST_IDX);
    asm_d = bus.frame_start ? '0 : asm_q;
    asm_d[{pos, 3'b000} +: 8] = bus.byte_in;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      asm_q         <= '0;
      frame_error_q <= 1'b0;
      blocks_done_q <= '0;
    end else begin
      frame_error_q <= accept &&
                       (((state_q == IDLE) && !bus.frame_start) ||
                        ((state_q == COLLECT) && bus.frame_start));
      if (store) begin
        if (last) begin
          state_q       <= IDLE;
          count_q       <= '0;
          asm_q         <= '0;
          blocks_done_q <= blocks_done_q + 16'd1;
        end else begin
          state_q <= COLLECT;
          count_q <= pos + CNT_W'(1);
          asm_q   <= asm_d;
        end
      end
    end
  end

  block_buffer_2entry #(
    .WIDTH(BLOCK_W)
  ) u_buffer (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (last),
    .push_data_i (asm_d),
    .pop_i       (buf_valid && bus.par_ready),
    .head_o      (buf_head),
    .valid_o     (buf_valid),
    .occupancy_o (occupancy)
  );

  assign bus.par_valid   = buf_valid;
  assign bus.par_data    = buf_head;
  assign bus.frame_error = frame_error_q;
  assign bus.blocks_done = blocks_done_q;
endmodule

// File: doc/serial_block_assembler.md
Name: serial_block_assembler

Overview:
- Receive-side counterpart to the parallel-to-serial conversion path: accepts a byte-serial lane and reassembles 4-word blocks (4*MAX_WORD_LENGTH bits) for downstream parallel consumers.
- One instance per lane; TILE_DIM instances sit side by side in the tile array.
- Byte input uses a valid/ready handshake with frame marking.
- Completed blocks pass through a 2-entry output buffer with a valid/ready handshake, so short downstream stalls do not throttle the serial lane.

Parameters:
- MAX_WORD_LENGTH, 32, bits per word; must be even so 4*MAX_WORD_LENGTH is a whole number of bytes.
- BYTES_PER_BLOCK, 4*MAX_WORD_LENGTH/8 (16 at default), derived; not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- byte_valid  input  1  byte_in holds a byte this cycle
- byte_in  input  8  serial data byte
- frame_start  input  1  qualifies byte_in as byte 0 of a block; sampled only with byte_valid
- byte_ready  output  1  assembler accepts a byte this cycle
- par_valid  output  1  par_data holds a complete block
- par_data  output  4*MAX_WORD_LENGTH  assembled block
- par_ready  input  1  consumer takes the block this cycle
- frame_error  output  1  one-cycle pulse on a framing violation
- blocks_done  output  16  count of blocks pushed to the buffer, wraps modulo 2^16

Behaviour:
- Clocking and reset:
  - One clock, clk. reset is synchronous and active-low: asserted when low, sampled on the rising edge of clk.
  - While reset=0, the next edge forces: state=IDLE, byte count=0, assembly register=0, buffer empty, par_valid=0, par_data=0, frame_error=0, blocks_done=0.
  - byte_ready=0 during reset; it is combinational and becomes 1 in the first cycle after reset releases.
  - Reset mid-block or mid-stall discards all partial and buffered data. No block is emitted.
- Byte acceptance: a byte is accepted when byte_valid && byte_ready. byte_ready = (buffer occupancy < 2). It does not depend on byte_valid.
- Packing: little-endian. Accepted byte k goes to assembly bits [8k+7:8k]. Byte 0 lands in par_data[7:0], and word j is par_data[32j+31:32j] at default width.
- FSM states:
  - IDLE:
    - Accepted byte with frame_start=1: store as byte 0, count=1, go to COLLECT.
    - Accepted byte with frame_start=0: drop the byte, pulse frame_error, stay in IDLE.
  - COLLECT:
    - Accepted byte with frame_start=0: store at position count, count++.
    - Accepted byte with frame_start=1: discard the partial block, pulse frame_error, store this byte as byte 0, count=1, stay in COLLECT.
    - When the accepted byte is byte BYTES_PER_BLOCK-1: push the completed block (including this byte) into the buffer, count=0, go to IDLE, blocks_done++.
- Latency: last byte accepted at edge N gives par_valid=1 with the full block visible after edge N (cycle N+1), assuming the buffer was empty.
- Output buffer:
  - 2-entry FIFO; its head drives par_valid and par_data.
  - A pop occurs when par_valid && par_ready.
  - par_data and par_valid hold stable while par_valid && !par_ready.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - With occupancy 2, byte_ready=0. The final byte of a block therefore can never arrive while the buffer is full, and no overflow case exists.
  - par_data=0 whenever the buffer is empty.
- frame_error is registered: high for exactly one cycle after the offending edge.
- Simultaneous events:
  - frame_error pulse and block push cannot coincide.
  - Pop and blocked input: byte_ready rises in the cycle after the pop edge.
- Width rules:
  - Byte counter is clog2(BYTES_PER_BLOCK) bits.
  - blocks_done wraps from 0xFFFF to 0x0000 without a flag.

Decomposition:
- Shared package:
  - State encoding (IDLE=0, COLLECT=1).
  - Function bytes_per_block(width).
  - Function clog2.
  - Both functions are shared with the transmit-side converter.
- Sub-module: block_buffer_2entry, a parameterised-width 2-deep FIFO with push, pop, head data, occupancy, and synchronous active-low reset. The remaining logic is the FSM, counter and assembly register in the top module.

Test Plan (MAX_WORD_LENGTH=32):
- Basic block: reset low 2 cycles, then 16 bytes 0x00..0x0F with frame_start on the first, par_ready=1 -> par_valid for exactly 1 cycle, one cycle after the last byte; par_data=0x0F0E0D0C_0B0A0908_07060504_03020100; blocks_done=1.
- Backpressure: par_ready=0, send 3 back-to-back blocks A, B, C:
  - byte_ready drops after B completes, and C's bytes are held off.
  - par_data=A stays stable.
  - Raise par_ready -> A, then B, then C delivered in order; no byte lost.
- Reframe mid-block: 5 bytes, then a byte 0xAA with frame_start=1, then 15 more bytes 0x01..0x0F -> one frame_error pulse; the single output block has par_data[7:0]=0xAA and par_data[127:120]=0x0F.
- Orphan bytes: 3 bytes with frame_start=0 in IDLE -> 3 frame_error pulses, no par_valid, blocks_done=0.
- Reset mid-operation: reset asserted after byte 9 with one block buffered -> next cycle par_valid=0, blocks_done=0. Then a fresh 16-byte block -> correct output with no leftover bytes.
- Counter wrap: force 65536 blocks with par_ready=1 -> blocks_done returns to 0x0000; the last block's data is correct.
